cpu_core_mc: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle 16-bit CPU top.
- Fetches 16-bit instructions and accesses data through request/acknowledge memory ports, so wait-state memories are supported.
- Adds immediates, load/store, branch, jump and a HALT state on top of register-register ALU ops.
- Sits as the core under a system top that instantiates the instruction and data memories.

---
 rtl/cpu_pkg.sv | 72 +++++++
 rtl/cpu_regfile_p.sv | 43 ++++
 rtl/cpu_core_mc.sv | 204 ++++++++++++++++++++
 tb/tb_cpu_core_mc.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the multi-cycle 16-bit core.
//   - opcode values (instruction bits [15:12])
//   - FSM state and ALU select enums
//   - instruction field positions
//   - alu_sel(): opcode to ALU operation mapping
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_ADDI = 4'd8;
  localparam logic [3:0] OP_LW   = 4'd9;
  localparam logic [3:0] OP_SW   = 4'd10;
  localparam logic [3:0] OP_BEQ  = 4'd11;
  localparam logic [3:0] OP_JMP  = 4'd12;
  localparam logic [3:0] OP_NOP0 = 4'd13;
  localparam logic [3:0] OP_NOP1 = 4'd14;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_SHL,
    ALU_SHR
  } alu_sel_e;

  // Instruction field positions
  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RS1_MSB = 11;
  localparam int unsigned RS1_LSB = 9;
  localparam int unsigned RS2_MSB = 8;   // rs2 (R-type) and rt (I-type) share bits
  localparam int unsigned RS2_LSB = 6;
  localparam int unsigned RD_MSB  = 5;
  localparam int unsigned RD_LSB  = 3;
  localparam int unsigned IMM_MSB = 5;
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned JT_MSB  = 11;

  function automatic alu_sel_e alu_sel(input logic [3:0] op);
    case (op)
      OP_ADD, OP_ADDI: return ALU_ADD;
      OP_SUB:          return ALU_SUB;
      OP_AND:          return ALU_AND;
      OP_OR:           return ALU_OR;
      OP_XOR:          return ALU_XOR;
      OP_SLT:          return ALU_SLT;
      OP_SHL:          return ALU_SHL;
      OP_SHR:          return ALU_SHR;
      default:         return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cpu_regfile_p.sv
// cpu_regfile_p: 8-entry register file, R0 hard-wired to zero.
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low clear of all entries
//   ra_i/rb_i  read addresses, rdata_a_o/rdata_b_o combinational read data
//   we_i, waddr_i, wdata_i  synchronous write port (writes to R0 dropped)
//   result_o   combinational view of R[RESULT_REG]
module cpu_regfile_p #(
  parameter int unsigned DW         = 16,
  parameter int unsigned RESULT_REG = 7
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [2:0]    ra_i,
  input  logic [2:0]    rb_i,
  output logic [DW-1:0] rdata_a_o,
  output logic [DW-1:0] rdata_b_o,
  input  logic          we_i,
  input  logic [2:0]    waddr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] result_o
);

  localparam logic [2:0] RIDX = 3'(RESULT_REG);

  logic [DW-1:0] regs_q [8];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 3'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = (ra_i == 3'd0) ? '0 : regs_q[ra_i];
    rdata_b_o = (rb_i == 3'd0) ? '0 : regs_q[rb_i];
    result_o  = (RIDX == 3'd0) ? '0 : regs_q[RIDX];
  end

endmodule

// File: rtl/cpu_core_mc.sv
// cpu_core_mc: multi-cycle CPU core with request/acknowledge memory ports.
//   clk, reset (async, active low)
//   imem_req/imem_addr/imem_ack/imem_rdata  instruction fetch handshake
//   dmem_req/dmem_we/dmem_addr/dmem_wdata/dmem_ack/dmem_rdata  data access
//   pc      current program counter (also the fetch address)
//   result  R[RESULT_REG], combinational from the register file
//   retire  one-cycle pulse per completed instruction
//   halted  high once HALT has executed, until reset
module cpu_core_mc
  import cpu_pkg::*;
#(
  parameter int unsigned DW         = 16,
  parameter int unsigned AW         = 16,
  parameter int unsigned RESULT_REG = 7
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [15:0]   imem_rdata,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] result,
  output logic          retire,
  output logic          halted
);

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [15:0]   instr_q;
  logic [DW-1:0] a_q, b_q, res_q;
  logic [AW-1:0] addr_q;
  logic          retire_q, halted_q;

  // Instruction fields
  logic [3:0]        op;
  logic [2:0]        rs1, rs2, rd;
  logic signed [5:0] imm6;
  logic [DW-1:0]     imm_dw;
  logic [AW-1:0]     imm_aw;
  logic [AW-1:0]     jmp_target;

  always_comb begin
    op         = instr_q[OP_MSB:OP_LSB];
    rs1        = instr_q[RS1_MSB:RS1_LSB];
    rs2        = instr_q[RS2_MSB:RS2_LSB];
    rd         = instr_q[RD_MSB:RD_LSB];
    imm6       = instr_q[IMM_MSB:IMM_LSB];
    imm_dw     = DW'(imm6);
    imm_aw     = AW'(imm6);
    jmp_target = AW'(instr_q[JT_MSB:0]);
  end

  // Register file
  logic [DW-1:0] rf_a, rf_b;
  logic          rf_we;
  logic [2:0]    rf_waddr;

  // ADDI and LW write rt; R-type ops write rd
  assign rf_we    = (state_q == S_WB);
  assign rf_waddr = op[3] ? rs2 : rd;

  cpu_regfile_p #(
    .DW        (DW),
    .RESULT_REG(RESULT_REG)
  ) u_regfile (
    .clk_i    (clk),
    .rst_ni   (reset),
    .ra_i     (rs1),
    .rb_i     (rs2),
    .rdata_a_o(rf_a),
    .rdata_b_o(rf_b),
    .we_i     (rf_we),
    .waddr_i  (rf_waddr),
    .wdata_i  (res_q),
    .result_o (result)
  );

  // Inline ALU
  logic [DW-1:0] alu_b, alu_d, ea_sum;
  logic [AW-1:0] ea_d;

  always_comb begin
    alu_b  = (op == OP_ADDI) ? imm_dw : b_q;
    alu_d  = '0;
    unique case (alu_sel(op))
      ALU_ADD: alu_d = a_q + alu_b;
      ALU_SUB: alu_d = a_q - alu_b;
      ALU_AND: alu_d = a_q & alu_b;
      ALU_OR:  alu_d = a_q | alu_b;
      ALU_XOR: alu_d = a_q ^ alu_b;
      ALU_SLT: alu_d[0] = ($signed(a_q) < $signed(alu_b));
      ALU_SHL: alu_d = a_q << alu_b[3:0];
      ALU_SHR: alu_d = a_q >> alu_b[3:0];
      default: alu_d = '0;
    endcase
    ea_sum = a_q + imm_dw;
    ea_d   = AW'(ea_sum);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      instr_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      addr_q   <= '0;
      retire_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            pc_q    <= pc_q + AW'(1);
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q     <= rf_a;
          b_q     <= rf_b;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          case (op)
            OP_LW, OP_SW: begin
              addr_q  <= ea_d;
              state_q <= S_MEM;
            end
            OP_BEQ: begin
              if (a_q == b_q) begin
                pc_q <= pc_q + imm_aw;
              end
              retire_q <= 1'b1;
              state_q  <= S_FETCH;
            end
            OP_JMP: begin
              pc_q     <= jmp_target;
              retire_q <= 1'b1;
              state_q  <= S_FETCH;
            end
            OP_NOP0, OP_NOP1: begin
              retire_q <= 1'b1;
              state_q  <= S_FETCH;
            end
            OP_HALT: begin
              retire_q <= 1'b1;
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end
            default: begin
              res_q   <= alu_d;
              state_q <= S_WB;
            end
          endcase
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (op == OP_LW) begin
              res_q   <= dmem_rdata;
              state_q <= S_WB;
            end else begin
              retire_q <= 1'b1;
              state_q  <= S_FETCH;
            end
          end
        end
        S_WB: begin
          retire_q <= 1'b1;
          state_q  <= S_FETCH;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  // Requests decode straight from the state so a fetch is issued in the very
  // first cycle after reset release; imem_req is also gated by reset because
  // the reset state is FETCH yet no request may be shown while reset is low.
  assign imem_req   = reset && (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = dmem_req && (op == OP_SW);
  assign dmem_addr  = addr_q;
  assign dmem_wdata = b_q;
  assign pc         = pc_q;
  assign retire     = retire_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_cpu_core_mc.sv
// tb_cpu_core_mc: directed programs against cpu_core_mc (DW=16, AW=12)
// with simple wait-state instruction/data memory models.
module tb_cpu_core_mc;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 12;

  localparam logic [3:0] I_ADD  = 4'd0;
  localparam logic [3:0] I_SUB  = 4'd1;
  localparam logic [3:0] I_SLT  = 4'd5;
  localparam logic [3:0] I_ADDI = 4'd8;
  localparam logic [3:0] I_LW   = 4'd9;
  localparam logic [3:0] I_SW   = 4'd10;
  localparam logic [3:0] I_BEQ  = 4'd11;
  localparam logic [15:0] W_HALT = 16'hF000;
  localparam logic [15:0] W_NOP  = 16'hD000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          imem_req, imem_ack;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_rdata;
  logic          dmem_req, dmem_we, dmem_ack;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata;
  logic [AW-1:0] pc;
  logic [DW-1:0] result;
  logic          retire, halted;

  cpu_core_mc #(
    .DW        (DW),
    .AW        (AW),
    .RESULT_REG(7)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_ack  (dmem_ack),
    .dmem_rdata(dmem_rdata),
    .pc        (pc),
    .result    (result),
    .retire    (retire),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  // Memory models
  logic [15:0]   imem [4096];
  logic [DW-1:0] dmem [4096];
  int unsigned   iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
  logic          force_iack = 1'b0;
  logic [AW-1:0] flog[$];

  assign imem_ack   = force_iack | (imem_req && (icnt >= iwait));
  assign imem_rdata = imem[imem_addr];
  assign dmem_ack   = dmem_req && (dcnt >= dwait);
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk) begin
    icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr] <= dmem_wdata;
  end

  always @(negedge clk) begin
    if (imem_req && imem_ack) flog.push_back(imem_addr);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] r_ins(input logic [3:0] op, input logic [2:0] rs1,
                                        input logic [2:0] rs2, input logic [2:0] rd);
    return {op, rs1, rs2, rd, 3'b000};
  endfunction

  function automatic logic [15:0] i_ins(input logic [3:0] op, input logic [2:0] rs1,
                                        input logic [2:0] rt, input logic [5:0] imm);
    return {op, rs1, rt, imm};
  endfunction

  // Holds reset low and clears memories; caller fills the program, then release().
  task automatic hold_reset();
    @(negedge clk);
    reset      = 1'b0;
    force_iack = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      imem[i] = W_HALT;
      dmem[i] = '0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    flog.delete();
    reset = 1'b1;
  endtask

  task automatic run_to_halt(input int max, output int cycles, output int rets);
    cycles = 0;
    rets   = 0;
    while (!halted && cycles < max) begin
      @(posedge clk); #1;
      cycles++;
      if (retire) rets++;
    end
  endtask

  task automatic step_retire(input string tag, input logic [DW-1:0] exp_res);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!retire && n < 40);
    check({tag, "_retire"}, 32'(retire), 32'd1);
    check({tag, "_result"}, 32'(result), 32'(exp_res));
  endtask

  int cyc, rets, n, bad;

  initial begin
    // Reset state
    #12;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_pc",       32'(pc),       32'd0);
    check("rst_retire",   32'(retire),   32'd0);
    check("rst_halted",   32'(halted),   32'd0);

    // Async reset while a fetch is stalled
    hold_reset();
    imem[0] = i_ins(I_ADDI, 3'd0, 3'd7, 6'd9);
    imem[1] = i_ins(I_ADDI, 3'd0, 3'd7, 6'd1);
    release_reset();
    step_retire("t0_addi", 16'd9);
    iwait = 5;
    repeat (2) begin @(posedge clk); #1; end
    check("t0_pre_req", 32'(imem_req), 32'd1);
    check("t0_pre_pc",  32'(pc),       32'd1);
    #3 reset = 1'b0;
    #1;
    check("t0_rst_req",    32'(imem_req), 32'd0);
    check("t0_rst_pc",     32'(pc),       32'd0);
    check("t0_rst_result", 32'(result),   32'd0);
    check("t0_rst_halted", 32'(halted),   32'd0);
    iwait = 0;

    // ADDI/ADDI/ADD/HALT, zero wait
    hold_reset();
    imem[0] = 16'h8045;  // ADDI R1,R0,5
    imem[1] = 16'h80BD;  // ADDI R2,R0,-3
    imem[2] = 16'h02B8;  // ADD  R7,R1,R2
    imem[3] = W_HALT;
    release_reset();
    run_to_halt(100, cyc, rets);
    check("t1_halted",  32'(halted), 32'd1);
    check("t1_cycles",  cyc,         15);
    check("t1_retires", rets,        4);
    check("t1_result",  32'(result), 32'h0002);
    check("t1_pc",      32'(pc),     32'd4);

    // Store/load with 3 data wait states
    hold_reset();
    dwait   = 3;
    imem[0] = i_ins(I_ADDI, 3'd0, 3'd1, 6'd31);
    imem[1] = i_ins(I_SW,   3'd0, 3'd1, 6'd10);
    imem[2] = i_ins(I_LW,   3'd0, 3'd7, 6'd10);
    imem[3] = W_HALT;
    release_reset();
    n = 0;
    while (!dmem_req && n < 50) begin @(posedge clk); #1; n++; end
    check("t2_dreq_seen", 32'(dmem_req), 32'd1);
    n   = 0;
    bad = 0;
    while (dmem_req && n < 20) begin
      n++;
      if (dmem_we !== 1'b1 || dmem_addr !== 12'd10 || dmem_wdata !== 16'd31) bad++;
      @(posedge clk); #1;
    end
    check("t2_sw_req_cycles", n,   4);
    check("t2_sw_unstable",   bad, 0);
    run_to_halt(100, cyc, rets);
    check("t2_halted", 32'(halted),   32'd1);
    check("t2_mem10",  32'(dmem[10]), 32'd31);
    check("t2_result", 32'(result),   32'd31);
    dwait = 0;

    // SUB wrap, signed SLT, R0 write discarded
    hold_reset();
    imem[0] = i_ins(I_ADDI, 3'd0, 3'd7, 6'd1);
    imem[1] = r_ins(I_SUB,  3'd0, 3'd7, 3'd7);
    imem[2] = r_ins(I_SLT,  3'd7, 3'd0, 3'd7);
    imem[3] = i_ins(I_ADDI, 3'd0, 3'd0, 6'd9);
    imem[4] = r_ins(I_ADD,  3'd0, 3'd0, 3'd7);
    imem[5] = W_HALT;
    release_reset();
    step_retire("t3_addi", 16'h0001);
    step_retire("t3_sub",  16'hFFFF);
    step_retire("t3_slt",  16'h0001);
    step_retire("t3_r0w",  16'h0001);
    step_retire("t3_r0rd", 16'h0000);

    // Branch taken / not taken, JMP to top, wrap
    hold_reset();
    imem[0]      = i_ins(I_BEQ,  3'd0, 3'd0, 6'd2);
    imem[3]      = i_ins(I_ADDI, 3'd0, 3'd1, 6'd7);
    imem[4]      = i_ins(I_BEQ,  3'd0, 3'd1, 6'd5);
    imem[5]      = 16'hCFFF;  // JMP 0xFFF
    imem[12'hFFF] = W_NOP;
    release_reset();
    n = 0;
    while (flog.size() < 6 && n < 100) begin @(posedge clk); #1; n++; end
    check("t4_fetch_count", 32'(flog.size() >= 6), 32'd1);
    if (flog.size() >= 6) begin
      check("t4_fetch0", 32'(flog[0]), 32'h000);
      check("t4_fetch1", 32'(flog[1]), 32'h003);
      check("t4_fetch2", 32'(flog[2]), 32'h004);
      check("t4_fetch3", 32'(flog[3]), 32'h005);
      check("t4_fetch4", 32'(flog[4]), 32'hFFF);
      check("t4_fetch5", 32'(flog[5]), 32'h000);
    end

    // Stray imem_ack during DECODE and in HALT
    hold_reset();
    imem[0] = i_ins(I_ADDI, 3'd0, 3'd7, 6'd3);
    imem[1] = W_HALT;
    release_reset();
    @(posedge clk); #1;
    check("t5_dec_req", 32'(imem_req), 32'd0);
    check("t5_dec_pc",  32'(pc),       32'd1);
    force_iack = 1'b1;
    @(posedge clk); #1;
    force_iack = 1'b0;
    check("t5_exec_req", 32'(imem_req), 32'd0);
    check("t5_exec_pc",  32'(pc),       32'd1);
    run_to_halt(100, cyc, rets);
    check("t5_cycles", cyc,         5);
    check("t5_result", 32'(result), 32'd3);
    check("t5_pc",     32'(pc),     32'd2);
    force_iack = 1'b1;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (imem_req !== 1'b0 || dmem_req !== 1'b0 || pc !== 12'd2 ||
          halted !== 1'b1 || retire !== 1'b0) bad++;
    end
    force_iack = 1'b0;
    check("t5_halt_frozen", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
